// File: rtl/div_core_arbiter.sv
// Round-robin front end for a shared serial digit-divider core: replays one
// requester's 4-digit frame into the core and returns the deserialised quotient.
module div_core_arbiter #(
   parameter int N_REQ   = 4,
   parameter int ID_W    = 2,
   parameter int TIMEOUT = 100,
   parameter int GAP_CYC = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [N_REQ-1:0]     req_valid,
   input  logic [16*N_REQ-1:0]  req_frame,
   output logic [N_REQ-1:0]     req_ready,
   output logic                 core_in_valid,
   output logic [3:0]           core_in_data,
   input  logic                 core_out_valid,
   input  logic                 core_out_data,
   output logic                 rsp_valid,
   output logic [ID_W-1:0]      rsp_id,
   output logic [9:0]           rsp_quot,
   output logic                 rsp_err
);

   typedef enum logic [2:0] {
      S_IDLE, S_SEND, S_WAIT, S_RECV, S_DRAIN, S_GAP
   } state_t;

   localparam logic [ID_W:0] NREQ_W    = (ID_W+1)'(N_REQ);
   localparam logic [6:0]    TIMEOUT_W = 7'(TIMEOUT - 1);
   localparam logic [7:0]    GAP_W     = 8'(GAP_CYC - 1);

   state_t          state_q, state_d;
   logic [ID_W-1:0] last_grant_q, last_grant_d;
   logic [11:0]     frame_q, frame_d;
   logic [1:0]      scnt_q, scnt_d;
   logic [6:0]      wcnt_q, wcnt_d;
   logic [3:0]      bcnt_q, bcnt_d;
   logic [7:0]      gcnt_q, gcnt_d;
   logic [9:0]      shift_q, shift_d;
   logic            err_q, err_d;
   logic            core_in_valid_q, core_in_valid_d;
   logic [3:0]      core_in_data_q, core_in_data_d;
   logic            rsp_valid_q, rsp_valid_d;
   logic [ID_W-1:0] rsp_id_q, rsp_id_d;
   logic [9:0]      rsp_quot_q, rsp_quot_d;
   logic            rsp_err_q, rsp_err_d;

   logic [15:0]     frames [N_REQ];
   logic            grant_any;
   logic [ID_W-1:0] grant_idx;
   logic [ID_W:0]   cand;
   logic            done, done_err;

   generate
      for (genvar gi = 0; gi < N_REQ; gi++) begin : g_frames
         assign frames[gi] = req_frame[16*gi +: 16];
      end
   endgenerate

   // Search starts one past the previous winner so every requester gets a turn.
   always_comb begin
      grant_any = 1'b0;
      grant_idx = '0;
      cand      = '0;
      for (int k = 1; k <= N_REQ; k++) begin
         cand = {1'b0, last_grant_q} + (ID_W+1)'(k);
         if (cand >= NREQ_W) cand = cand - NREQ_W;
         if (!grant_any && req_valid[cand[ID_W-1:0]]) begin
            grant_any = 1'b1;
            grant_idx = cand[ID_W-1:0];
         end
      end
   end

   always_comb begin
      req_ready = '0;
      if (state_q == S_IDLE && rst_n && grant_any) req_ready[grant_idx] = 1'b1;
   end

   always_comb begin
      state_d         = state_q;
      last_grant_d    = last_grant_q;
      frame_d         = frame_q;
      scnt_d          = scnt_q;
      wcnt_d          = wcnt_q;
      bcnt_d          = bcnt_q;
      gcnt_d          = gcnt_q;
      shift_d         = shift_q;
      err_d           = err_q;
      core_in_valid_d = 1'b0;
      core_in_data_d  = '0;
      done            = 1'b0;
      done_err        = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (grant_any) begin
               last_grant_d    = grant_idx;
               frame_d         = frames[grant_idx][11:0];
               core_in_valid_d = 1'b1;
               core_in_data_d  = frames[grant_idx][15:12];
               scnt_d          = '0;
               err_d           = 1'b0;
               state_d         = S_SEND;
            end
         end
         S_SEND: begin
            if (core_out_valid) err_d = 1'b1;
            if (scnt_q == 2'd3) begin
               wcnt_d  = '0;
               shift_d = '0;
               state_d = S_WAIT;
            end else begin
               core_in_valid_d = 1'b1;
               core_in_data_d  = frame_q[11:8];
               frame_d         = {frame_q[7:0], 4'h0};
               scnt_d          = scnt_q + 2'd1;
            end
         end
         S_WAIT: begin
            if (core_out_valid) begin
               shift_d = {9'd0, core_out_data};
               bcnt_d  = 4'd1;
               state_d = S_RECV;
            end else if (wcnt_q == TIMEOUT_W) begin
               done     = 1'b1;
               done_err = 1'b1;
               state_d  = S_DRAIN;
            end else begin
               wcnt_d = wcnt_q + 7'd1;
            end
         end
         S_RECV: begin
            if (core_out_valid) begin
               if (bcnt_q == 4'd10) begin
                  done     = 1'b1;
                  done_err = 1'b1;
                  state_d  = S_DRAIN;
               end else begin
                  shift_d = {shift_q[8:0], core_out_data};
                  bcnt_d  = bcnt_q + 4'd1;
               end
            end else begin
               done     = 1'b1;
               done_err = err_q || (bcnt_q != 4'd10);
               gcnt_d   = '0;
               state_d  = S_GAP;
            end
         end
         S_DRAIN: begin
            if (!core_out_valid) begin
               gcnt_d  = '0;
               state_d = S_GAP;
            end
         end
         S_GAP: begin
            if (core_out_valid) begin
               gcnt_d = '0;
            end else if (gcnt_q == GAP_W) begin
               gcnt_d  = '0;
               state_d = S_IDLE;
            end else begin
               gcnt_d = gcnt_q + 8'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      rsp_valid_d = done;
      rsp_id_d    = done ? last_grant_q : '0;
      rsp_err_d   = done && done_err;
      rsp_quot_d  = (done && !done_err) ? shift_q : '0;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q         <= S_IDLE;
         last_grant_q    <= ID_W'(N_REQ - 1);
         frame_q         <= '0;
         scnt_q          <= '0;
         wcnt_q          <= '0;
         bcnt_q          <= '0;
         gcnt_q          <= '0;
         shift_q         <= '0;
         err_q           <= 1'b0;
         core_in_valid_q <= 1'b0;
         core_in_data_q  <= '0;
         rsp_valid_q     <= 1'b0;
         rsp_id_q        <= '0;
         rsp_quot_q      <= '0;
         rsp_err_q       <= 1'b0;
      end else begin
         state_q         <= state_d;
         last_grant_q    <= last_grant_d;
         frame_q         <= frame_d;
         scnt_q          <= scnt_d;
         wcnt_q          <= wcnt_d;
         bcnt_q          <= bcnt_d;
         gcnt_q          <= gcnt_d;
         shift_q         <= shift_d;
         err_q           <= err_d;
         core_in_valid_q <= core_in_valid_d;
         core_in_data_q  <= core_in_data_d;
         rsp_valid_q     <= rsp_valid_d;
         rsp_id_q        <= rsp_id_d;
         rsp_quot_q      <= rsp_quot_d;
         rsp_err_q       <= rsp_err_d;
      end
   end

   assign core_in_valid = core_in_valid_q;
   assign core_in_data  = core_in_data_q;
   assign rsp_valid     = rsp_valid_q;
   assign rsp_id        = rsp_id_q;
   assign rsp_quot      = rsp_quot_q;
   assign rsp_err       = rsp_err_q;

endmodule

// File: doc/div_core_arbiter.md
# div_core_arbiter

Round-robin scheduler that shares one serial digit-divider core among `N_REQ` requesters. It accepts a 4-digit excess-3 frame from the granted requester and replays it into the core as a 4-cycle `in_valid` burst. It then deserialises the core's 10-bit MSB-first quotient and returns it, tagged with the requester ID, as a one-cycle response. It also polices the core protocol (latency timeout, output length) and enforces the mandatory idle gap between core jobs.

## Interface
- `N_REQ`, 4 — number of requesters (2..8).
- `ID_W`, 2 — `$clog2(N_REQ)`, width of `rsp_id`.
- `TIMEOUT`, 100 — maximum cycles from the last input digit to the first `core_out_valid`.
- `GAP_CYC`, 2 — minimum consecutive cycles with `core_out_valid==0` before the next burst.

- `clk` — in, 1 — single clock; all state updates on the rising edge.
- `rst_n` — in, 1 — reset, synchronous, active-low.
- `req_valid` — in, `N_REQ` — requester i has a frame pending.
- `req_frame` — in, `16*N_REQ` — frame i occupies `[16i+15:16i]`; four excess-3 digits, `[15:12]` sent first.
- `req_ready` — out, `N_REQ` — one-hot grant; frame i is captured on the edge where it is high.
- `core_in_valid` — out, 1 — drives the core's `in_valid`.
- `core_in_data` — out, 4 — drives the core's `in_data`; 0 whenever `core_in_valid==0`.
- `core_out_valid` — in, 1 — core result strobe.
- `core_out_data` — in, 1 — core serial quotient bit.
- `rsp_valid` — out, 1 — one-cycle response pulse.
- `rsp_id` — out, `ID_W` — index of the requester that owns the response.
- `rsp_quot` — out, 10 — quotient; 1023 is passed through unchanged (core's divide-by-zero code).
- `rsp_err` — out, 1 — protocol violation; `rsp_quot` is forced to 0 when set.

## Operation
- **States:** IDLE, SEND, WAIT, RECV, DRAIN, GAP.
- **IDLE:** if any `req_valid` is set, grant the first set index after `last_grant`, wrapping modulo `N_REQ`.
  - `req_ready[g]` is combinational and high in IDLE only; the frame is latched, `last_grant<=g`, next state SEND.
  - Reset value of `last_grant` is `N_REQ-1`, so requester 0 wins first.
- **SEND:** 4 cycles. `core_in_valid=1`; `core_in_data` = frame nibbles `[15:12]`, `[11:8]`, `[7:4]`, `[3:0]` in order. Then WAIT with `wcnt=0`.
- **WAIT:** each cycle with `core_out_valid==0`, `wcnt++`.
  - `wcnt==TIMEOUT-1` → `rsp_err`, then DRAIN.
  - `core_out_valid==1` → shift in `core_out_data` as bit 9, `bcnt=1`, go to RECV.
- **RECV:** while `core_out_valid==1` and `bcnt<10`, shift in MSB-first and `bcnt++`.
  - Low with `bcnt==10` → good response, then GAP.
  - Low with `bcnt<10` → `rsp_err`, then GAP.
  - High with `bcnt==10` (11th bit) → `rsp_err`, then DRAIN.
- **DRAIN:** wait for `core_out_valid==0`, then GAP.
- **GAP:** count consecutive low-`core_out_valid` cycles; a high cycle resets the count. On reaching `GAP_CYC` → IDLE.
- **Core valid during SEND:** `core_out_valid==1` in SEND sets a sticky error. SEND still completes; the response carries `rsp_err=1`.
- **Arithmetic:** `wcnt` is 7 bits and `bcnt` is 4 bits; neither saturates past its terminal value.
- **Lost requesters:** a requester that drops `req_valid` before its grant is simply skipped. Frames are never partially consumed.

## Timing
- **Reset:** `rsp_valid`, `rsp_err`, `rsp_quot`, `rsp_id`, `core_in_valid`, `core_in_data` and `req_ready` are 0; state=IDLE; counters are 0.
  - Reset asserted mid-operation aborts the job within one edge: no response, `core_in_valid` low next cycle.
- **Grant to burst:** grant at cycle T; `core_in_valid` is high T+1..T+4.
- **Response:** `rsp_valid` is registered, asserted the cycle after the terminating event (`core_out_valid` falling, timeout, or 11th bit), high for exactly 1 cycle.
- **Throughput:** minimum spacing from `rsp_valid` to the next `core_in_valid` is `GAP_CYC+1` cycles.
- **Arbitration conflicts:**
  - Simultaneous requests: rotation is strict; with all requesters active, the grant order is 0,1,2,3,0…
  - A request arriving during a job waits; grants are only issued in IDLE.

## Test plan
- **Single request:** requester 2, frame 16'hC63A (digits 9,3,0,7), core model returns 132 → `core_in_data` C,6,3,A at T+1..T+4; `rsp_valid` with `rsp_id=2`, `rsp_quot=10'd132`, `rsp_err=0`.
- **Round-robin:** all four `req_valid` held high for 8 jobs → `rsp_id` sequence 0,1,2,3,0,1,2,3; each `req_ready` is a one-hot, 1-cycle pulse.
- **Timeout:** core never raises `core_out_valid` → `rsp_err=1` and `rsp_quot=0` exactly `TIMEOUT` cycles after the last input digit; next grant only after `GAP_CYC` low cycles.
- **Bad length:** core gives 9 valid bits, then 12 valid bits on the next job → both jobs return `rsp_err=1`; for the 12-bit job no grant occurs until valid drops plus `GAP_CYC` cycles.
- **Divide-by-zero code:** core returns 1023 → `rsp_quot=10'd1023`, `rsp_err=0`.
- **Reset mid-RECV:** `rst_n=0` at bit 5 → no `rsp_valid`; all outputs 0 on the next edge; the first grant after release goes to requester 0.
